// File: rtl/axis_bk_rx_fifo.sv
// Backend RX buffer: DEPTH-entry FWFT FIFO of AXI-Stream beats plus sideband, with packet count and sticky overflow.
// One-cycle write-to-read latency; bk_ready is registered and keeps a 2-entry skid margin for the post-deassert beat.
module axis_bk_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic [31:0]              bk_data,
    input  logic [3:0]               bk_tstrb,
    input  logic [3:0]               bk_tkeep,
    input  logic [1:0]               bk_user,
    input  logic                     bk_tlast,
    input  logic                     bk_valid,
    output logic                     bk_ready,
    output logic [31:0]              rd_data,
    output logic [3:0]               rd_tstrb,
    output logic [3:0]               rd_tkeep,
    output logic [1:0]               rd_user,
    output logic                     rd_tlast,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    input  logic                     fifo_clr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]  user;
        logic        tlast;
        logic [3:0]  tkeep;
        logic [3:0]  tstrb;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   pkt_next;
    logic [CW-1:0]   free_next;
    logic            full;
    logic            wr;
    logic            rd;
    logic            ovf_set;

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd       = rd_valid && rd_ready;
    // bk_ready is deliberately absent: the slave's late beat must still land.
    assign wr       = bk_valid && (!full || rd);
    assign ovf_set  = bk_valid && full && !rd;

    always_comb begin
        head = '0;
        if (rd_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign rd_data  = head.data;
    assign rd_tstrb = head.tstrb;
    assign rd_tkeep = head.tkeep;
    assign rd_user  = head.user;
    assign rd_tlast = head.tlast;

    always_comb begin
        count_next = count;
        if (wr && !rd) begin
            count_next = count + CW'(1);
        end else if (!wr && rd) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        pkt_next = pkt_cnt;
        if ((wr && bk_tlast) && !(rd && head.tlast)) begin
            pkt_next = pkt_cnt + CW'(1);
        end else if (!(wr && bk_tlast) && (rd && head.tlast)) begin
            pkt_next = pkt_cnt - CW'(1);
        end
    end

    assign free_next = CW'(DEPTH) - count_next;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pkt_cnt  <= '0;
            overflow <= 1'b0;
            bk_ready <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pkt_cnt  <= '0;
            overflow <= 1'b0;
            bk_ready <= 1'b1;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_next;
            pkt_cnt <= pkt_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            bk_ready <= (free_next >= CW'(2));
        end
    end

    // Storage needs no reset; rd_valid masks stale contents.
    always_ff @(posedge axi_aclk) begin
        if (wr && !fifo_clr) begin
            mem[wr_ptr] <= '{user: bk_user, tlast: bk_tlast, tkeep: bk_tkeep,
                             tstrb: bk_tstrb, data: bk_data};
        end
    end

endmodule

// File: tb/tb_axis_bk_rx_fifo.sv
// Directed vector bench for axis_bk_rx_fifo (DEPTH=8): table of per-cycle stimulus and expected post-edge outputs.
module tb_axis_bk_rx_fifo;

    logic        axi_aclk = 1'b0;
    logic        axi_areset;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_tlast;
    logic        bk_valid;
    logic        bk_ready;
    logic [31:0] rd_data;
    logic [3:0]  rd_tstrb;
    logic [3:0]  rd_tkeep;
    logic [1:0]  rd_user;
    logic        rd_tlast;
    logic        rd_valid;
    logic        rd_ready;
    logic        fifo_clr;
    logic [3:0]  count;
    logic [3:0]  pkt_cnt;
    logic        overflow;

    axis_bk_rx_fifo #(.DEPTH(8)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep), .bk_user(bk_user),
        .bk_tlast(bk_tlast), .bk_valid(bk_valid), .bk_ready(bk_ready),
        .rd_data(rd_data), .rd_tstrb(rd_tstrb), .rd_tkeep(rd_tkeep), .rd_user(rd_user),
        .rd_tlast(rd_tlast), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_clr(fifo_clr), .count(count), .pkt_cnt(pkt_cnt), .overflow(overflow)
    );

    always #5 axi_aclk = ~axi_aclk;

    // side packs {user, tkeep, tstrb}
    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        tl;
        logic [9:0]  side;
        logic        rr;
        logic        clr;
        int          e_cnt;
        int          e_pkt;
        logic        e_rdy;
        logic        e_ovf;
        logic [31:0] e_dat;
        logic        e_tl;
        logic [9:0]  e_side;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [9:0] S1 = 10'h0FF;
    localparam logic [9:0] S2 = 10'h2F3;

    task automatic add(input logic v, input logic [31:0] d, input logic tl, input logic [9:0] side,
                       input logic rr, input logic clr, input int e_cnt, input int e_pkt,
                       input logic e_rdy, input logic e_ovf, input logic [31:0] e_dat,
                       input logic e_tl, input logic [9:0] e_side);
        vec_t x;
        x.v = v; x.d = d; x.tl = tl; x.side = side; x.rr = rr; x.clr = clr;
        x.e_cnt = e_cnt; x.e_pkt = e_pkt; x.e_rdy = e_rdy; x.e_ovf = e_ovf;
        x.e_dat = e_dat; x.e_tl = e_tl; x.e_side = e_side;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic tl, input logic [9:0] side,
                         input logic rr, input logic clr);
        bk_valid = v; bk_data = d; bk_tlast = tl;
        bk_user = side[9:8]; bk_tkeep = side[7:4]; bk_tstrb = side[3:0];
        rd_ready = rr; fifo_clr = clr;
    endtask

    task automatic check_state(input string tag, input int e_cnt, input int e_pkt, input logic e_rdy,
                               input logic e_ovf, input logic [31:0] e_dat, input logic e_tl,
                               input logic [9:0] e_side);
        chk({tag, ".count"},    32'(count),    32'(e_cnt));
        chk({tag, ".pkt_cnt"},  32'(pkt_cnt),  32'(e_pkt));
        chk({tag, ".bk_ready"}, 32'(bk_ready), 32'(e_rdy));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_cnt != 0));
        chk({tag, ".rd_data"},  rd_data,       e_dat);
        chk({tag, ".rd_tlast"}, 32'(rd_tlast), 32'(e_tl));
        chk({tag, ".rd_side"},  32'({rd_user, rd_tkeep, rd_tstrb}), 32'(e_side));
    endtask

    initial begin
        // first edge after reset release raises bk_ready
        add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        // stream 5 beats with the consumer always ready
        for (int i = 1; i <= 5; i++)
            add(1, 32'(i), i == 5, S1, 1, 0,  1, (i == 5) ? 1 : 0, 1, 0, 32'(i), i == 5, S1);
        add(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0);
        // fill: bk_ready drops after the write leaving one slot, late beat still lands
        for (int k = 1; k <= 8; k++)
            add(1, 32'h10 + 32'(k), 0, S1, 0, 0,  k, 0, k <= 6, 0, 32'h11, 0, S1);
        // full with simultaneous write and read, wrapping pointers
        for (int k = 1; k <= 4; k++)
            add(1, 32'h18 + 32'(k), 0, S1, 1, 0,  8, 0, 0, 0, 32'h11 + 32'(k), 0, S1);
        // lone beat while full is dropped; overflow is sticky
        add(1, 32'h99, 0, S1, 0, 0,  8, 0, 0, 1, 32'h15, 0, S1);
        add(0, 0, 0, 0, 0, 0,        8, 0, 0, 1, 32'h15, 0, S1);
        add(0, 0, 0, 0, 0, 1,        0, 0, 1, 0, 0, 0, 0);
        // three 2-beat packets, then one packet read
        for (int k = 1; k <= 6; k++)
            add(1, 32'h20 + 32'(k), (k % 2) == 0, S2, 0, 0,  k, k / 2, 1, 0, 32'h21, 0, S2);
        add(0, 0, 0, 0, 1, 0,  5, 3, 1, 0, 32'h22, 1, S2);
        add(0, 0, 0, 0, 1, 0,  4, 2, 1, 0, 32'h23, 0, S2);
        add(1, 32'h27, 0, S2, 0, 0,  5, 2, 1, 0, 32'h23, 0, S2);
        // clear beats concurrent write and read
        add(1, 32'h28, 1, S2, 1, 1,  0, 0, 1, 0, 0, 0, 0);

        axi_areset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        check_state("reset", 0, 0, 0, 0, 0, 0, 0);
        axi_areset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge axi_aclk);
            drive(vecs[i].v, vecs[i].d, vecs[i].tl, vecs[i].side, vecs[i].rr, vecs[i].clr);
            @(posedge axi_aclk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_pkt, vecs[i].e_rdy,
                        vecs[i].e_ovf, vecs[i].e_dat, vecs[i].e_tl, vecs[i].e_side);
        end

        // asynchronous reset in the middle of a partial packet
        for (int k = 1; k <= 3; k++) begin
            @(negedge axi_aclk);
            drive(1, 32'h30 + 32'(k), 0, S1, 0, 0);
        end
        @(posedge axi_aclk);
        #1;
        check_state("pre_rst", 3, 0, 1, 0, 32'h31, 0, S1);
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        axi_areset = 1'b1;
        #1;
        check_state("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        @(posedge axi_aclk);
        #1;
        check_state("post_rst_idle", 0, 0, 1, 0, 0, 0, 0);
        @(negedge axi_aclk);
        drive(1, 32'hA5, 1, S2, 0, 0);
        @(posedge axi_aclk);
        #1;
        check_state("post_rst_wr", 1, 1, 1, 0, 32'hA5, 1, S2);
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 1, 0);
        @(posedge axi_aclk);
        #1;
        check_state("post_rst_rd", 0, 0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_bk_rx_fifo.md
# axis_bk_rx_fifo

Backend receive buffer placed directly downstream of the AXI-Stream slave. It consumes the slave's bk_* beat interface and stores beats with their sideband in a DEPTH-entry FIFO, and presents them to the user core on a valid/ready read port. bk_ready is driven with skid margin, because the slave can still deliver one valid beat in the cycle after bk_ready falls. The block also tracks complete packets held in the buffer and flags overflow.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥4
- axi_aclk  in  1  clock; all logic on rising edge
- axi_areset  in  1  asynchronous, active-high reset
- bk_data  in  32  beat data from slave
- bk_tstrb  in  4  byte strobes
- bk_tkeep  in  4  byte keeps
- bk_user  in  2  user sideband
- bk_tlast  in  1  last beat of packet
- bk_valid  in  1  beat present this cycle
- bk_ready  out  1  registered; buffer can take beats
- rd_data  out  32  head entry data
- rd_tstrb  out  4  head entry tstrb
- rd_tkeep  out  4  head entry tkeep
- rd_user  out  2  head entry user
- rd_tlast  out  1  head entry tlast
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  consumer pops head when rd_valid
- fifo_clr  in  1  synchronous flush
- count  out  clog2(DEPTH)+1  entries stored
- pkt_cnt  out  clog2(DEPTH)+1  tlast beats stored (complete packets)
- overflow  out  1  sticky; beat dropped while full

## Operation
- Storage: DEPTH × 43-bit entry {user, tlast, tkeep, tstrb, data}. Write and read pointers are clog2(DEPTH) bits and wrap naturally. count is a separate counter.
- Write fire (wr): bk_valid && (count < DEPTH || rd). bk_ready is not part of the write qualifier. Beats arriving while bk_ready=0 are still accepted, which covers the slave's short-transaction exception beat.
- Read fire (rd): rd_valid && rd_ready.
- Output path is first-word-fall-through. rd_* shows the head entry combinationally from the array.
  - rd_valid = (count != 0).
  - When empty, rd_* data and sideband outputs are 0.
- count_next = count + wr − rd. Simultaneous wr and rd leave count unchanged, including when count = DEPTH: the write is accepted into the slot freed that cycle.
- pkt_cnt: +1 on wr with bk_tlast=1; −1 on rd with rd_tlast=1; both in the same cycle means no change.
- bk_ready register:
  - Next value is (DEPTH − count_next) ≥ 2.
  - The 2-entry margin absorbs one normal beat plus one post-deassert beat from the slave.
- overflow is set when bk_valid && count == DEPTH && !rd. The beat is discarded. overflow stays set until fifo_clr or reset.
- fifo_clr has priority over wr and rd in the same cycle:
  - pointers, count, pkt_cnt and overflow go to 0;
  - bk_ready goes to 1 on the next edge.

## Timing
- Reset (axi_areset=1, asynchronous): bk_ready=0, count=0, pkt_cnt=0, overflow=0, rd_valid=0, all rd_* = 0, pointers=0. Array contents are don't-care.
- First edge after reset release: bk_ready goes to 1.
- Latency: a beat written at edge N is visible on rd_* with rd_valid=1 after edge N, i.e. one cycle.
- bk_ready is one cycle behind occupancy.
  - After a wr that leaves 1 free entry, bk_ready drops at the next edge.
  - The one remaining slot takes the late beat.
  - No loss occurs with a compliant upstream.
- Full (count=DEPTH): bk_ready=0 and rd_valid=1. A lone bk_valid is dropped and sets overflow. bk_valid together with rd is accepted.
- Empty: rd_ready is ignored. A write and a read of the same slot cannot occur in the same cycle.
- Reset asserted mid-packet: all state clears immediately. Partial packet contents are lost and pkt_cnt=0.

## Test plan
- Reset then stream 5 beats (data 0x1..0x5, tlast on 5th), rd_ready=1 → same data and tlast on rd_* one cycle after each write; pkt_cnt peaks at 1 and returns to 0; overflow=0.
- DEPTH=8, rd_ready=0, bk_valid held high → bk_ready falls after the write that leaves 1 free entry. The extra beat lands, giving count=8 with no overflow. A 9th beat then sets overflow=1 and count stays 8.
- Full buffer, bk_valid=1 and rd_ready=1 together for 4 cycles → count stays 8, overflow=0, read order is strict FIFO across pointer wrap.
- Three 2-beat packets written, then one 2-beat packet read → pkt_cnt goes 1,2,3 then 2. tstrb=0x3, tkeep=0xF and user=0x2 are preserved per beat.
- fifo_clr asserted together with wr and rd at count=5 → next cycle count=0, pkt_cnt=0, rd_valid=0, overflow=0, bk_ready=1.
- axi_areset pulsed mid-packet with count=3 → outputs go to reset values asynchronously. Post-reset traffic 0xA5 reads back correctly.
